// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the data-memory stage.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } mem_state_t;

    // Byte enables for an access; reserved size behaves as a full word.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // True when the low address bits do not suit the access size, or size is reserved.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Request/response bundle between the core control FSM and the memory stage.
// Latency: n/a (wires only).
// Backpressure: requester must hold off while ready is low; inputs are ignored then.
interface mem_stage_ctrl_if;
    logic        req;
    logic        ready;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        resp_valid;
    logic        resp_err;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  ready, rdata, resp_valid, resp_err
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output ready, rdata, resp_valid, resp_err
    );
endinterface

// File: rtl/mem_byte_ram.sv
// DEPTH x 32 synchronous RAM with per-byte write enable and registered read.
// Latency: read data appears one edge after rd_idx is presented.
// Backpressure: none; one read and one write per cycle. Contents are not reset.
module mem_byte_ram #(
    parameter int DEPTH = 1024,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH];

    // Byte-lane writes; lanes with a clear enable keep their old contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Registered read port (old data on a same-address write).
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Data-memory stage: byte/half/word loads and stores with sign/zero extension.
// Latency: resp_valid pulses WAIT_CYCLES edges after acceptance; one access per WAIT_CYCLES+2 cycles.
// Backpressure: ready is low outside IDLE and requests are ignored then. Alignment faults: MEM_ALIGN_CHK_EN.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_stage_ctrl_if.slave  bus
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int AW    = IDX_W + 2;

    mem_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             q_we;
    logic [1:0]       q_size;
    logic             q_sign_ext;
    logic [AW-1:0]    q_addr;
    logic [31:0]      q_wdata;
    logic [31:0]      rdata_q;
    logic             resp_valid_q;

    logic             commit;
    logic             fault;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      ram_q;
    logic [31:0]      load_val;

    // Address bits above the RAM window are dropped so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:AW];

    assign bus.ready      = (state == ST_IDLE);
    assign bus.rdata      = rdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign commit         = (state == ST_WAIT) && (cnt == '0);

`ifdef MEM_ALIGN_CHK_EN
    logic resp_err_q;

    assign fault        = misaligned(q_size, q_addr[1:0]);
    assign bus.resp_err = resp_err_q;

    // Fault flag is raised with the completion pulse and dropped with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err_q <= 1'b0;
        end else if (commit) begin
            resp_err_q <= fault;
        end else if (state == ST_RESP) begin
            resp_err_q <= 1'b0;
        end
    end
`else
    assign fault        = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    // While idle the RAM reads the incoming address so the word is ready by commit.
    assign rd_idx = bus.ready ? bus.addr[AW-1:2] : q_addr[AW-1:2];

    // Store steering: replicate the low byte/half across lanes; the mask picks the lane.
    always_comb begin
        wr_data = q_wdata;
        case (q_size)
            SZ_BYTE: wr_data = {4{q_wdata[7:0]}};
            SZ_HALF: wr_data = {2{q_wdata[15:0]}};
            default: wr_data = q_wdata;
        endcase
        wr_be = (commit && q_we && !fault) ? lane_mask(q_size, q_addr[1:0]) : 4'b0000;
    end

    // Load steering: right-justify the selected lane, then extend.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'h00;
        h = 16'h0000;
        case (q_addr[1:0])
            2'd0:    b = ram_q[7:0];
            2'd1:    b = ram_q[15:8];
            2'd2:    b = ram_q[23:16];
            default: b = ram_q[31:24];
        endcase
        h = q_addr[1] ? ram_q[31:16] : ram_q[15:0];
        case (q_size)
            SZ_BYTE: load_val = q_sign_ext ? {{24{b[7]}}, b} : {24'h0, b};
            SZ_HALF: load_val = q_sign_ext ? {{16{h[15]}}, h} : {16'h0, h};
            default: load_val = ram_q;
        endcase
    end

    mem_byte_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rd_idx  (rd_idx),
        .wr_idx  (q_addr[AW-1:2]),
        .wr_be   (wr_be),
        .wr_data (wr_data),
        .rd_data (ram_q)
    );

    // Control FSM: accept in IDLE, count down in WAIT, pulse the response in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            q_we         <= 1'b0;
            q_size       <= SZ_BYTE;
            q_sign_ext   <= 1'b0;
            q_addr       <= '0;
            q_wdata      <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    resp_valid_q <= 1'b0;
                    if (bus.req) begin
                        q_we       <= bus.we;
                        q_size     <= bus.size;
                        q_sign_ext <= bus.sign_ext;
                        q_addr     <= bus.addr[AW-1:0];
                        q_wdata    <= bus.wdata;
                        cnt        <= CNT_W'(WAIT_CYCLES - 1);
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        if (fault) begin
                            rdata_q <= '0;
                        end else if (!q_we) begin
                            rdata_q <= load_val;
                        end
                        resp_valid_q <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: one 1024-word/1-wait instance and one 16-word/3-wait instance.
// Latency: checks resp_valid timing and ready-low window per access.
// Backpressure: exercises req held high while the stage is busy.
module tb_mem_stage_ctrl;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl_if a_if ();
    mem_stage_ctrl_if b_if ();

    mem_stage_ctrl #(.DEPTH(1024), .WAIT_CYCLES(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    mem_stage_ctrl #(.DEPTH(16), .WAIT_CYCLES(3)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int which, input logic r, input logic w, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] d);
        if (which == 0) begin
            a_if.req = r; a_if.we = w; a_if.size = sz; a_if.sign_ext = sx; a_if.addr = a; a_if.wdata = d;
        end else begin
            b_if.req = r; b_if.we = w; b_if.size = sz; b_if.sign_ext = sx; b_if.addr = a; b_if.wdata = d;
        end
    endtask

    task automatic sample(input int which, output logic rdy, output logic vld,
                          output logic err, output logic [31:0] rd);
        if (which == 0) begin
            rdy = a_if.ready; vld = a_if.resp_valid; err = a_if.resp_err; rd = a_if.rdata;
        end else begin
            rdy = b_if.ready; vld = b_if.resp_valid; err = b_if.resp_err; rd = b_if.rdata;
        end
    endtask

    // One access; lat = edges after acceptance until resp_valid seen, -1 on timeout.
    task automatic acc(input int which, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d, input bit hold,
                       output logic [31:0] rd, output logic er, output int lat, output int rdy_low);
        logic rdy, vld, e;
        logic [31:0] r;
        int pulses;
        @(negedge clk);
        set_in(which, 1'b1, w, sz, sx, a, d);
        @(posedge clk);
        #1;
        if (hold) set_in(which, 1'b1, ~w, sz, sx, 32'h0000_0008, ~d);
        else      set_in(which, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        lat = -1; rdy_low = 0; rd = 32'h0; er = 1'b0; pulses = 0;
        for (int k = 0; k < 30; k++) begin
            sample(which, rdy, vld, e, r);
            if (!rdy) rdy_low++;
            if (vld) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; rd = r; er = e;
                end
            end
            if (rdy && k > 0) break;
            @(posedge clk);
            #1;
        end
        set_in(which, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        if (pulses != 1) lat = -1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          rl;
    logic        s_rdy, s_vld, s_err;
    logic [31:0] s_rd;

    initial begin
        set_in(0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        set_in(1, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        sample(0, s_rdy, s_vld, s_err, s_rd);
        check("rst_ready", {31'h0, s_rdy}, 32'h1);
        check("rst_valid", {31'h0, s_vld}, 32'h0);
        check("rst_rdata", s_rd, 32'h0);
        check("rst_err", {31'h0, s_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store/load, 1 wait cycle
        acc(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, rd, er, lat, rl);
        check("st_word_lat", lat, 32'd1);
        check("st_word_rdylow", rl, 32'd2);
        acc(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, rl);
        check("ld_word_lat", lat, 32'd1);
        check("ld_word", rd, 32'hDEADBEEF);
        acc(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, rl);
        check("st_keeps_rdata", rd, 32'hDEADBEEF);

        // Byte store into lane 3, then extension variants
        acc(0, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h12345680, 1'b0, rd, er, lat, rl);
        acc(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, rl);
        check("byte_word_view", rd, 32'h80000000);
        acc(0, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 1'b0, rd, er, lat, rl);
        check("ld_byte_sx", rd, 32'hFFFFFF80);
        acc(0, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 1'b0, rd, er, lat, rl);
        check("ld_byte_zx", rd, 32'h00000080);

        // Half lanes
        acc(0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hAAAAAAAA, 1'b0, rd, er, lat, rl);
        acc(0, 1'b1, SZ_HALF, 1'b0, 32'h22, 32'hFFFF1234, 1'b0, rd, er, lat, rl);
        acc(0, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat, rl);
        check("half_word_view", rd, 32'h1234AAAA);
        acc(0, 1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 1'b0, rd, er, lat, rl);
        check("ld_half_hi_zx", rd, 32'h00001234);
        acc(0, 1'b1, SZ_HALF, 1'b0, 32'h20, 32'h00008001, 1'b0, rd, er, lat, rl);
        acc(0, 1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0, 1'b0, rd, er, lat, rl);
        check("ld_half_sx", rd, 32'hFFFF8001);
        acc(0, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat, rl);
        check("half_lo_word_view", rd, 32'h12348001);

        // Reset during WAIT discards the pending store
        acc(0, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'hCAFEF00D, 1'b0, rd, er, lat, rl);
        @(negedge clk);
        set_in(0, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'h11111111);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        sample(0, s_rdy, s_vld, s_err, s_rd);
        check("abort_ready", {31'h0, s_rdy}, 32'h1);
        check("abort_valid", {31'h0, s_vld}, 32'h0);
        check("abort_rdata", s_rd, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        acc(0, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 1'b0, rd, er, lat, rl);
        check("abort_no_write", rd, 32'hCAFEF00D);

`ifdef MEM_ALIGN_CHK_EN
        acc(0, 1'b1, SZ_WORD, 1'b0, 32'h11, 32'h55555555, 1'b0, rd, er, lat, rl);
        check("mis_word_err", {31'h0, er}, 32'h1);
        check("mis_word_rdata", rd, 32'h0);
        check("mis_word_lat", lat, 32'd1);
        acc(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, rl);
        check("mis_mem_kept", rd, 32'h80000000);
        check("aligned_err", {31'h0, er}, 32'h0);
        acc(0, 1'b0, SZ_RSVD, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, rl);
        check("rsvd_err", {31'h0, er}, 32'h1);
        check("rsvd_rdata", rd, 32'h0);
        acc(0, 1'b0, SZ_HALF, 1'b0, 32'h21, 32'h0, 1'b0, rd, er, lat, rl);
        check("mis_half_err", {31'h0, er}, 32'h1);
`else
        acc(0, 1'b1, SZ_WORD, 1'b0, 32'h11, 32'h55555555, 1'b0, rd, er, lat, rl);
        check("mis_word_err", {31'h0, er}, 32'h0);
        check("mis_word_rdata", rd, 32'hCAFEF00D);
        acc(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, rl);
        check("mis_word_trunc", rd, 32'h55555555);
        acc(0, 1'b0, SZ_RSVD, 1'b1, 32'h10, 32'h0, 1'b0, rd, er, lat, rl);
        check("rsvd_as_word", rd, 32'h55555555);
        acc(0, 1'b0, SZ_HALF, 1'b0, 32'h21, 32'h0, 1'b0, rd, er, lat, rl);
        check("mis_half_trunc", rd, 32'h00008001);
`endif

        // Wrap and stall: DEPTH=16, WAIT_CYCLES=3
        acc(1, 1'b1, SZ_WORD, 1'b0, 32'h08, 32'h12121212, 1'b0, rd, er, lat, rl);
        check("b_lat", lat, 32'd3);
        check("b_rdylow", rl, 32'd4);
        acc(1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h0BADCAFE, 1'b1, rd, er, lat, rl);
        check("b_hold_lat", lat, 32'd3);
        check("b_hold_rdylow", rl, 32'd4);
        acc(1, 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, 1'b0, rd, er, lat, rl);
        check("b_wrap", rd, 32'h0BADCAFE);
        acc(1, 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, 1'b0, rd, er, lat, rl);
        check("b_hold_ignored", rd, 32'h12121212);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Parametrised data-memory stage for the multi-cycle MIPS core; successor to the fixed 1K-word single-cycle data RAM. Adds byte/halfword/word loads and stores with sign or zero extension, configurable depth, and configurable access latency. Uses a req/ready/resp_valid handshake so the control FSM can stall on memory. Sits between the ALU address output and the write-back mux.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, at least 4.
WAIT_CYCLES, 1, cycles from request acceptance to commit; at least 1.
IDX_W, $clog2(DEPTH), word-index width; derived, not overridden.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  access request
ready  out  1  high when idle and able to accept req
we  in  1  1 = store, 0 = load; sampled with req
size  in  2  00 byte, 01 half, 10 word, 11 reserved
sign_ext  in  1  loads: 1 = sign-extend, 0 = zero-extend
addr  in  32  byte address from ALU
wdata  in  32  store data; byte/half taken from the low bits
rdata  out  32  load result; valid with resp_valid
resp_valid  out  1  one-cycle completion pulse, for loads and stores
resp_err  out  1  access fault; valid with resp_valid (MEM_ALIGN_CHK_EN only)

Behaviour:
- Reset (async, rst_n=0): state IDLE, ready=1, resp_valid=0, rdata=0, resp_err=0, wait counter 0. RAM contents are not reset.
- FSM states are IDLE, WAIT, RESP. ready = (state==IDLE), combinational from state only.
- IDLE: on an edge with req=1, latch we, size, sign_ext, addr and wdata. Go to WAIT with counter = WAIT_CYCLES-1.
- WAIT: decrement the counter each edge. On the edge where counter==0, commit the access, register rdata, set resp_valid=1 and go to RESP.
- RESP: resp_valid is high for exactly this cycle. The next edge clears it and returns to IDLE. rdata holds until the next commit.
- Timing: req accepted at edge E. resp_valid is high in the cycle after edge E+WAIT_CYCLES. ready returns after edge E+WAIT_CYCLES+1. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Inputs are ignored while ready=0.
- Word index = addr[IDX_W+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- Byte lane = addr[1:0]; half lane = addr[1]. Lanes are little-endian: byte 0 is bits 7:0.
- Store: only the selected lane(s) are written; other bytes keep their value. Word store writes all 4 bytes.
- Load: the selected lane is right-justified, then sign- or zero-extended per sign_ext. Word loads ignore sign_ext.
- Stores return rdata unchanged from its previous value.
- Without the feature, size 11 is treated as word.
- Reset mid-operation: an access not yet committed is discarded with no RAM write. A store already committed remains.

Optional Feature:
Macro MEM_ALIGN_CHK_EN.
- Defined: a fault is any of:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - size=11.
  A faulting access performs no RAM write, returns rdata=0, and sets resp_err=1 with resp_valid. Timing is unchanged.
- Not defined: resp_err is tied to 0. Misaligned low address bits are truncated: half uses addr[1] only, word ignores addr[1:0].

Decomposition:
- Package mem_stage_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - the FSM state enum;
  - the lane-mask function (size, addr[1:0]) -> 4-bit byte enable.
- One sub-module, mem_byte_ram: DEPTH x 32 synchronous RAM with a 4-bit byte-write enable and registered read.
- The controller holds the FSM, wait counter, lane steering and extension logic.

Test Plan:
- Reset then idle: rst_n low mid-WAIT -> ready=1, resp_valid=0, rdata=0; a later load of the same address shows no write from the aborted store.
- Word store then load, WAIT_CYCLES=1: store 0xDEADBEEF @0x10, then load @0x10 -> resp_valid 2 cycles after each accept, rdata=0xDEADBEEF.
- Byte store and extension: store byte 0x80 @0x13 over 0x00000000, then:
  - word load @0x10 -> 0x80000000;
  - byte load @0x13, sign_ext=1 -> 0xFFFFFF80;
  - sign_ext=0 -> 0x00000080.
- Half lanes: store half 0x1234 @0x22 over 0xAAAAAAAA -> word @0x20 = 0x1234AAAA; signed half load of 0x8001 -> 0xFFFF8001.
- Wrap and stall, DEPTH=16, WAIT_CYCLES=3:
  - store @0x40 then load @0x0 -> same data;
  - ready low for 4 cycles after accept;
  - req held during WAIT is ignored.
- MEM_ALIGN_CHK_EN: word store @0x11 -> resp_err=1, rdata=0, memory unchanged; aligned access -> resp_err=0.
